bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Round-robin arbiter and master multiplexer for the shared system bus. Four bus masters, each driven by one `bus_if` instance (IF stage, MEM stage, and two spare master channels), request the bus through active-low `Req_` lines. The arbiter registers one owner and drives the owner's address, strobe, direction and write data onto the shared slave-side bus. It sits directly downstream of `bus_if`: it consumes `BusReq_`/`BusAddr`/`BusAs_`/`BusRW`/`BusWrData` and returns `BusGrnt_`.

## Interface
- `WORD_ADDR_W`, 30: word address width (`WORD_ADDR_BUS`).
- `WORD_DATA_W`, 32: data width (`WORD_DATA_BUS`).
- Master count is fixed at 4; it is not a parameter.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `reset_`  in  1  asynchronous, active-low reset.
- `M0Req_`..`M3Req_`  in  1 each  bus request from master N, active-low.
- `M0Addr`..`M3Addr`  in  WORD_ADDR_W each  master N word address.
- `M0As_`..`M3As_`  in  1 each  master N address strobe, active-low.
- `M0RW`..`M3RW`  in  1 each  master N direction (`READ`/`WRITE`).
- `M0WrData`..`M3WrData`  in  WORD_DATA_W each  master N write data.
- `M0Grnt_`..`M3Grnt_`  out  1 each  grant to master N, active-low, registered.
- `SAddr`  out  WORD_ADDR_W  shared bus address (owner's `MnAddr`).
- `SAs_`  out  1  shared address strobe (owner's `MnAs_`).
- `SRW`  out  1  shared direction (owner's `MnRW`).
- `SWrData`  out  WORD_DATA_W  shared write data (owner's `MnWrData`).

## Operation
- State is a 2-bit `owner` register. Reset value is 0 (master 0). On reset, `M0Grnt_`=`ENABLE_` and `M1..M3Grnt_`=`DISABLE_`.
- Exactly one `MnGrnt_` is `ENABLE_` at all times, namely `MnGrnt_` with n == `owner`. The grant outputs are flops updated together with `owner`.
- The bus is parked on the last owner when nobody requests.
- Next-owner rule, evaluated every cycle:
  - If `Mowner Req_`==`ENABLE_`, the owner is held. There is no preemption, no timeout, and no fairness override while a grant is in use.
  - Otherwise, scan masters owner+1, owner+2, owner+3 (mod 4) in that order. The first with `Req_`==`ENABLE_` becomes the owner.
  - If none requests, the owner is unchanged.
- Simultaneous requests are resolved purely by the scan order above. The scan wraps from 3 to 0.
- Shared-bus mux is combinational from `owner`. `SAddr`/`SAs_`/`SRW`/`SWrData` follow the current owner's inputs in the same cycle.
- No other master's inputs reach the slave side.
- Reset asserted mid-transfer immediately forces `owner`=0 and grant to master 0. The mux switches to master 0 without waiting for `Rdy_`.

## Timing
- Grant latency: the owner is idle and master N first drives `Req_` low before edge k. `MnGrnt_` goes low after edge k, i.e. it is visible in cycle k+1. The minimum latency is 1 clock.
- Release: the owner drives `Req_` high before edge k while master M requests. `MmGrnt_` goes low and the old grant goes high after edge k. There is no dead cycle between owners.
- Requester waiting behind an active owner: its grant appears 1 cycle after the owner releases.
- Worst-case wait for a requester is 3 complete ownerships.
- The mux has zero latency: a change in the owner's `As_` appears on `SAs_` in the same cycle.
- Handshake: a master must keep `Req_` low until its access completes (`Rdy_` observed). The arbiter does not observe `Rdy_`.

## Structure
- The shared header `bus.vh` holds:
  - `BUS_OWNER_BUS` (`[1:0]`)
  - `BUS_OWNER_MASTER_0`..`BUS_OWNER_MASTER_3`
  - `BUS_MASTER_CH` (4)
- The existing `WORD_ADDR_BUS`/`WORD_DATA_BUS`/`ENABLE_`/`DISABLE_`/`READ`/`WRITE`/`RESET_EDGE` come from `nettype.vh`, `global_config.vh` and `cpu.vh`.
- Sub-module `bus_master_mux` is purely combinational. Its inputs are `owner` and the four master bundles; its outputs are `SAddr`/`SAs_`/`SRW`/`SWrData`.
- `bus_arbiter` holds the owner/grant flops and the next-owner logic.

## Test plan
- Reset, then all `Req_` high for 10 cycles: `owner`=0, `M0Grnt_`=0, others 1 throughout. `SAddr` tracks `M0Addr`=0x0000_1234.
- Only M2 requests at cycle 5: `M2Grnt_`=0 from cycle 6. `SAddr` equals `M2Addr`=0x0100_0040 from cycle 6. Holding `Req_` 4 cycles keeps the grant; releasing it parks the bus on M2.
- All four request at once from owner=0, with M0 released first: grant order M1, M2, M3, M0. Each owner holds for 3 cycles, and handover has no idle cycle.
- Owner M3 releases while M0 and M1 both request: M0 is granted (wrap-around scan).
- Owner M1 mid-access with `SAs_`=0 while M2 requests: M1 keeps the grant until its `Req_` goes high. `SAs_`/`SRW`/`SWrData` never show M2 values during that time.
- `reset_` pulsed low while M3 owns with `SRW`=`WRITE`: asynchronously `M0Grnt_`=0 and `M3Grnt_`=1, and the mux outputs follow M0 within the reset cycle.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// bus_arbiter_pkg
//   Shared definitions for the system-bus arbiter: signal polarities, the
//   bus owner encoding and the round-robin next-owner / grant-decode helpers.
// ----------------------------------------------------------------------------
package bus_arbiter_pkg;

    // Number of bus masters (IF stage, MEM stage and two spare channels).
    localparam int BUS_MASTER_CH = 4;

    // Active-low control polarity used across the bus.
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    // Bus direction encoding.
    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

    typedef enum logic [1:0] {
        BUS_OWNER_MASTER_0 = 2'd0,
        BUS_OWNER_MASTER_1 = 2'd1,
        BUS_OWNER_MASTER_2 = 2'd2,
        BUS_OWNER_MASTER_3 = 2'd3
    } bus_owner_e;

    // Round-robin next owner. The current owner keeps the bus while its
    // request is active; otherwise the masters after it are scanned in
    // order owner+1, owner+2, owner+3 (wrapping 3 -> 0). With no request
    // the bus stays parked on the current owner.
    function automatic bus_owner_e next_owner(
        input bus_owner_e owner,
        input logic [BUS_MASTER_CH-1:0] req_n
    );
        logic [1:0] cur;
        logic [1:0] cand;
        cur        = owner;
        next_owner = owner;
        if (req_n[cur] != ENABLE_) begin
            // Scan farthest to nearest so the nearest requester is the
            // last assignment and therefore wins.
            for (int i = BUS_MASTER_CH - 1; i >= 1; i--) begin
                cand = cur + 2'(i);
                if (req_n[cand] == ENABLE_) begin
                    next_owner = bus_owner_e'(cand);
                end
            end
        end
    endfunction

    // Active-low one-hot grant vector for a given owner.
    function automatic logic [BUS_MASTER_CH-1:0] grant_vec(input bus_owner_e owner);
        logic [1:0] idx;
        idx       = owner;
        grant_vec = {BUS_MASTER_CH{DISABLE_}};
        grant_vec[idx] = ENABLE_;
    endfunction

endpackage : bus_arbiter_pkg

// File: rtl/bus_master_mux.sv
// ----------------------------------------------------------------------------
// bus_master_mux
//   Purely combinational selector that drives the owner's address, strobe,
//   direction and write data onto the shared slave-side bus. Only the
//   owner's bundle is ever forwarded.
//
// Ports
//   owner                  current bus owner
//   MnAddr/MnAs_/MnRW/MnWrData  bundle from master n (n = 0..3)
//   SAddr/SAs_/SRW/SWrData      shared slave-side bus
// ----------------------------------------------------------------------------
module bus_master_mux
    import bus_arbiter_pkg::*;
#(
    parameter int WORD_ADDR_W = 30,
    parameter int WORD_DATA_W = 32
) (
    input  bus_owner_e             owner,
    input  logic [WORD_ADDR_W-1:0] M0Addr,
    input  logic                   M0As_,
    input  logic                   M0RW,
    input  logic [WORD_DATA_W-1:0] M0WrData,
    input  logic [WORD_ADDR_W-1:0] M1Addr,
    input  logic                   M1As_,
    input  logic                   M1RW,
    input  logic [WORD_DATA_W-1:0] M1WrData,
    input  logic [WORD_ADDR_W-1:0] M2Addr,
    input  logic                   M2As_,
    input  logic                   M2RW,
    input  logic [WORD_DATA_W-1:0] M2WrData,
    input  logic [WORD_ADDR_W-1:0] M3Addr,
    input  logic                   M3As_,
    input  logic                   M3RW,
    input  logic [WORD_DATA_W-1:0] M3WrData,
    output logic [WORD_ADDR_W-1:0] SAddr,
    output logic                   SAs_,
    output logic                   SRW,
    output logic [WORD_DATA_W-1:0] SWrData
);

    always_comb begin
        // NOTE: every output gets a default first so no path through the
        // case can leave one unassigned and infer a latch.
        SAddr   = M0Addr;
        SAs_    = M0As_;
        SRW     = M0RW;
        SWrData = M0WrData;
        case (owner)
            BUS_OWNER_MASTER_1: begin
                SAddr   = M1Addr;
                SAs_    = M1As_;
                SRW     = M1RW;
                SWrData = M1WrData;
            end
            BUS_OWNER_MASTER_2: begin
                SAddr   = M2Addr;
                SAs_    = M2As_;
                SRW     = M2RW;
                SWrData = M2WrData;
            end
            BUS_OWNER_MASTER_3: begin
                SAddr   = M3Addr;
                SAs_    = M3As_;
                SRW     = M3RW;
                SWrData = M3WrData;
            end
            default: ;
        endcase
    end

endmodule : bus_master_mux

// File: rtl/bus_arbiter.sv
// ----------------------------------------------------------------------------
// bus_arbiter
//   Round-robin arbiter for four bus masters. Holds the registered owner and
//   active-low grant flops, and instantiates the combinational master mux
//   that drives the shared slave-side bus from the current owner.
//
// Ports
//   clk, reset_                 clock, asynchronous active-low reset
//   MnReq_                      bus request from master n, active-low
//   MnAddr/MnAs_/MnRW/MnWrData  bundle from master n
//   MnGrnt_                     registered grant to master n, active-low
//   SAddr/SAs_/SRW/SWrData      shared slave-side bus (owner's bundle)
// ----------------------------------------------------------------------------
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int WORD_ADDR_W = 30,
    parameter int WORD_DATA_W = 32
) (
    input  logic                   clk,
    input  logic                   reset_,
    input  logic                   M0Req_,
    input  logic [WORD_ADDR_W-1:0] M0Addr,
    input  logic                   M0As_,
    input  logic                   M0RW,
    input  logic [WORD_DATA_W-1:0] M0WrData,
    output logic                   M0Grnt_,
    input  logic                   M1Req_,
    input  logic [WORD_ADDR_W-1:0] M1Addr,
    input  logic                   M1As_,
    input  logic                   M1RW,
    input  logic [WORD_DATA_W-1:0] M1WrData,
    output logic                   M1Grnt_,
    input  logic                   M2Req_,
    input  logic [WORD_ADDR_W-1:0] M2Addr,
    input  logic                   M2As_,
    input  logic                   M2RW,
    input  logic [WORD_DATA_W-1:0] M2WrData,
    output logic                   M2Grnt_,
    input  logic                   M3Req_,
    input  logic [WORD_ADDR_W-1:0] M3Addr,
    input  logic                   M3As_,
    input  logic                   M3RW,
    input  logic [WORD_DATA_W-1:0] M3WrData,
    output logic                   M3Grnt_,
    output logic [WORD_ADDR_W-1:0] SAddr,
    output logic                   SAs_,
    output logic                   SRW,
    output logic [WORD_DATA_W-1:0] SWrData
);

    bus_owner_e                 owner;
    bus_owner_e                 owner_next;
    logic [BUS_MASTER_CH-1:0]   req_n;
    logic [BUS_MASTER_CH-1:0]   grnt_n;

    assign req_n = {M3Req_, M2Req_, M1Req_, M0Req_};

    always_comb begin
        owner_next = next_owner(owner, req_n);
    end

    // Grants are their own flops (not decoded from owner) so the outputs
    // come straight from registers; both are loaded from the same value.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            // NOTE: state uses non-blocking assignments so every flop
            // samples pre-edge values regardless of statement order.
            owner  <= BUS_OWNER_MASTER_0;
            grnt_n <= grant_vec(BUS_OWNER_MASTER_0);
        end else begin
            owner  <= owner_next;
            grnt_n <= grant_vec(owner_next);
        end
    end

    assign M0Grnt_ = grnt_n[0];
    assign M1Grnt_ = grnt_n[1];
    assign M2Grnt_ = grnt_n[2];
    assign M3Grnt_ = grnt_n[3];

    bus_master_mux #(
        .WORD_ADDR_W (WORD_ADDR_W),
        .WORD_DATA_W (WORD_DATA_W)
    ) u_mux (
        .owner    (owner),
        .M0Addr   (M0Addr),
        .M0As_    (M0As_),
        .M0RW     (M0RW),
        .M0WrData (M0WrData),
        .M1Addr   (M1Addr),
        .M1As_    (M1As_),
        .M1RW     (M1RW),
        .M1WrData (M1WrData),
        .M2Addr   (M2Addr),
        .M2As_    (M2As_),
        .M2RW     (M2RW),
        .M2WrData (M2WrData),
        .M3Addr   (M3Addr),
        .M3As_    (M3As_),
        .M3RW     (M3RW),
        .M3WrData (M3WrData),
        .SAddr    (SAddr),
        .SAs_     (SAs_),
        .SRW      (SRW),
        .SWrData  (SWrData)
    );

endmodule : bus_arbiter

// File: tb/tb_bus_arbiter.sv
// ----------------------------------------------------------------------------
// tb_bus_arbiter
//   Directed, table-driven bench for bus_arbiter with hand-written sequences
//   for rotation, mid-access hold and asynchronous reset.
// ----------------------------------------------------------------------------
module tb_bus_arbiter;

    localparam int AW = 30;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset_;
    logic [3:0]    req_n;
    logic [AW-1:0] addr  [4];
    logic [3:0]    as_n;
    logic [3:0]    rw;
    logic [DW-1:0] wdata [4];

    logic          M0Grnt_, M1Grnt_, M2Grnt_, M3Grnt_;
    logic [AW-1:0] SAddr;
    logic          SAs_;
    logic          SRW;
    logic [DW-1:0] SWrData;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic [3:0] req_n;      // {M3,M2,M1,M0} Req_
        int         exp_owner;  // owner expected after the next edge
    } vec_t;

    vec_t vecs [17];

    always #5 clk = ~clk;

    bus_arbiter #(.WORD_ADDR_W(AW), .WORD_DATA_W(DW)) dut (
        .clk      (clk),
        .reset_   (reset_),
        .M0Req_   (req_n[0]), .M0Addr (addr[0]), .M0As_ (as_n[0]), .M0RW (rw[0]), .M0WrData (wdata[0]), .M0Grnt_ (M0Grnt_),
        .M1Req_   (req_n[1]), .M1Addr (addr[1]), .M1As_ (as_n[1]), .M1RW (rw[1]), .M1WrData (wdata[1]), .M1Grnt_ (M1Grnt_),
        .M2Req_   (req_n[2]), .M2Addr (addr[2]), .M2As_ (as_n[2]), .M2RW (rw[2]), .M2WrData (wdata[2]), .M2Grnt_ (M2Grnt_),
        .M3Req_   (req_n[3]), .M3Addr (addr[3]), .M3As_ (as_n[3]), .M3RW (rw[3]), .M3WrData (wdata[3]), .M3Grnt_ (M3Grnt_),
        .SAddr    (SAddr),
        .SAs_     (SAs_),
        .SRW      (SRW),
        .SWrData  (SWrData)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Grants are one-hot active-low on owner o; the shared bus carries
    // master o's bundle as driven by this bench.
    task automatic check_bus(input string tag, input int o);
        logic [3:0] exp_g;
        exp_g = 4'b1111;
        exp_g[o] = 1'b0;
        check({tag, " grant"}, {28'd0, M3Grnt_, M2Grnt_, M1Grnt_, M0Grnt_}, {28'd0, exp_g});
        check({tag, " SAddr"}, {2'd0, SAddr}, {2'd0, addr[o]});
        check({tag, " SAs_"}, {31'd0, SAs_}, {31'd0, as_n[o]});
        check({tag, " SRW"}, {31'd0, SRW}, {31'd0, rw[o]});
        check({tag, " SWrData"}, SWrData, wdata[o]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        addr[0]  = 30'h0000_1234;
        addr[1]  = 30'h0000_2000;
        addr[2]  = 30'h0100_0040;
        addr[3]  = 30'h0300_0ABC;
        as_n     = 4'b0101;            // M1, M3 strobing
        rw       = 4'b0101;            // M0, M2 READ; M1, M3 WRITE
        wdata[0] = 32'hA0A0_0000;
        wdata[1] = 32'hB1B1_1111;
        wdata[2] = 32'hC2C2_2222;
        wdata[3] = 32'hD3D3_3333;

        // Starts from owner 0 after the idle period.
        vecs[0]  = '{4'b1111, 0};
        vecs[1]  = '{4'b1011, 2};      // only M2 requests
        vecs[2]  = '{4'b1011, 2};
        vecs[3]  = '{4'b1011, 2};
        vecs[4]  = '{4'b1011, 2};
        vecs[5]  = '{4'b1111, 2};      // released: parked on M2
        vecs[6]  = '{4'b1111, 2};
        vecs[7]  = '{4'b0000, 2};      // owner still requesting: held
        vecs[8]  = '{4'b0100, 3};      // M2 releases: scan starts at M3
        vecs[9]  = '{4'b0000, 3};
        vecs[10] = '{4'b1100, 0};      // M3 releases, M0+M1 request: wrap to M0
        vecs[11] = '{4'b1100, 0};
        vecs[12] = '{4'b1101, 1};
        vecs[13] = '{4'b1011, 2};
        vecs[14] = '{4'b1110, 0};      // scan 3 then 0
        vecs[15] = '{4'b0111, 3};
        vecs[16] = '{4'b1111, 3};

        // Reset state, checked while reset is still asserted.
        reset_ = 1'b0;
        req_n  = 4'b1111;
        #12;
        check_bus("reset", 0);
        @(negedge clk);
        reset_ = 1'b1;

        // Idle for 10 cycles: parked on M0.
        for (int i = 0; i < 10; i++) begin
            tick();
            check_bus($sformatf("idle%0d", i), 0);
        end

        // Table-driven vectors.
        for (int i = 0; i < 17; i++) begin
            req_n = vecs[i].req_n;
            tick();
            check_bus($sformatf("vec%0d", i), vecs[i].exp_owner);
        end

        // Rotation: all request from owner 0; each owner holds 3 cycles,
        // then releases while the previous owners request again.
        req_n = 4'b1110;
        tick();
        check_bus("rot_start", 0);
        req_n = 4'b0000;
        tick();
        check_bus("rot_all", 0);
        for (int p = 0; p < 4; p++) begin
            req_n = 4'b0000;
            req_n[p] = 1'b1;           // current owner p releases
            for (int c = 0; c < 3; c++) begin
                tick();
                check_bus($sformatf("rot_p%0d_c%0d", p, c), (p + 1) % 4);
                if (c == 0) req_n = 4'b0000;
            end
        end

        // M1 mid-access, M2 waiting: M1 keeps the bus.
        req_n = 4'b1101;
        tick();
        check_bus("mid_grant", 1);
        req_n = 4'b1001;
        for (int c = 0; c < 3; c++) begin
            tick();
            check_bus($sformatf("mid_hold%0d", c), 1);
        end
        // Zero-latency strobe mux.
        #1 as_n[1] = 1'b1;
        #1 check("mid_as_hi", {31'd0, SAs_}, 32'd1);
        as_n[1] = 1'b0;
        #1 check("mid_as_lo", {31'd0, SAs_}, 32'd0);
        req_n = 4'b1011;
        tick();
        check_bus("mid_release", 2);

        // Asynchronous reset while M3 owns with a write.
        req_n = 4'b0111;
        tick();
        check_bus("pre_reset", 3);
        check("pre_reset write", {31'd0, SRW}, 32'd0);
        #2 reset_ = 1'b0;
        #1 check_bus("async_reset", 0);
        @(negedge clk);
        reset_ = 1'b1;
        tick();
        check_bus("post_reset", 3);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_bus_arbiter
